uart_sector_packer: RTL
=======================

// Module: uart_sector_packer
// PURPOSE
//  Sits between the UART byte receiver and the SD-card write controller in the UART-to-SD logging path.
//  Packs received bytes into 16-bit words and buffers them in a word FIFO.
//  When a full 512-byte sector is buffered, requests an SD write at the current sector address.
//  Streams the sector on the controller's per-word strobe, then advances the address on completion.
// PARAMETERS
//  START_ADDR    32'h0  first SD sector address written after reset
//  FIFO_DEPTH    1024   word FIFO depth; power of two, >= SECTOR_WORDS
//  SECTOR_WORDS  256    16-bit words per SD sector (512 bytes)
// PORTS
//  sys_clk    in   1   system clock, 50 MHz
//  sys_rst    in   1   asynchronous reset, active high
//  rx_flag    in   1   one-cycle strobe: rx_data valid
//  rx_data    in   8   received UART byte
//  wr_busy    in   1   SD controller busy with a sector write
//  wr_en      in   1   SD controller samples wr_data this cycle; one pulse per word
//  wr_req     out  1   one-cycle pulse: start sector write at wr_addr
//  wr_addr    out  32  sector address of the pending/active write
//  wr_data    out  16  head word of FIFO (show-ahead)
//  fill       out  11  words currently in FIFO (log2(FIFO_DEPTH)+1 bits)
//  overflow   out  1   sticky: a completed word was dropped because FIFO full
// BEHAVIOUR
//  Reset (async, sys_rst=1): wr_req=0, wr_addr=START_ADDR, wr_data=0, fill=0, overflow=0.
//   Byte-pair register is cleared, FIFO pointers are zeroed, FSM goes to IDLE. Applies mid-transfer as well.
//  Packing:
//   - First byte of a pair goes to [15:8], second byte to [7:0].
//   - The word is pushed in the cycle after the second rx_flag.
//   - A lone odd byte is held indefinitely; it is never flushed.
//  FIFO and wr_data:
//   - wr_data always shows the head word. On wr_en, pop; the new head appears on wr_data the next cycle.
//   - Push and pop in the same cycle: fill unchanged; both take effect.
//   - Push when fill==FIFO_DEPTH (and no same-cycle pop): word dropped, overflow set to 1 until reset.
//   - wr_en when fill==0: ignored (no pop, pointers unchanged); the word counter still advances.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM:
//   - IDLE: if fill>=SECTOR_WORDS and wr_busy==0 -> REQ.
//   - REQ: wr_req=1 for exactly one cycle -> WAIT.
//   - WAIT: wait for wr_busy==1 -> XFER; wr_en already counts in WAIT.
//   - XFER: count wr_en pulses (9-bit counter). At SECTOR_WORDS pulses -> DONE.
//     Extra wr_en pulses beyond SECTOR_WORDS in the same sector are ignored (no pop).
//   - DONE: wait for wr_busy==0, then wr_addr<=wr_addr+1 (32-bit, wraps FFFFFFFF->0) -> IDLE.
//  wr_addr is stable from REQ through DONE and changes only on the DONE->IDLE transition.
//  Latency: the 256th word is pushed -> wr_req is asserted 2 cycles later if wr_busy==0.
//  Back-to-back: if >=SECTOR_WORDS words remain after DONE, REQ is entered on the next cycle.
//  Bytes continue to be accepted in every state.
// TESTING
//  1. Reset, then 512 bytes 00..FF,00..FF:
//     -> one wr_req with wr_addr=0; words 0x0001,0x0203,..; after 256 wr_en, fill=0 and wr_addr=1.
//  2. 511 bytes only -> no wr_req; fill=255; one byte held; the 512th byte triggers wr_req.
//  3. 1536 bytes, controller model consumes slowly
//     -> three requests at addresses 0,1,2 in order; data continuity across sectors.
//  4. Controller stalled (wr_busy=1); push 1025 words
//     -> overflow=1; fill=1024; 1025th word absent from read-back.
//  5. sys_rst pulsed after 100 wr_en in XFER
//     -> wr_req=0, wr_addr=START_ADDR, fill=0, overflow=0 immediately (async).
//  6. Push and wr_en coincide at fill=256 -> fill stays 256; FIFO order preserved.

Source files
------------

// File: rtl/uart_sector_packer.sv
// Packs UART bytes into 16-bit words, buffers them in a word FIFO and hands
// complete 512-byte sectors to the SD write controller, one sector address at a time.
module uart_sector_packer #(
  parameter logic [31:0] START_ADDR   = 32'h0,
  parameter int          FIFO_DEPTH   = 1024,
  parameter int          SECTOR_WORDS = 256
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          rx_flag,
  input  logic [7:0]                    rx_data,
  input  logic                          wr_busy,
  input  logic                          wr_en,
  output logic                          wr_req,
  output logic [31:0]                   wr_addr,
  output logic [15:0]                   wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SECTOR_WORDS + 1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   SECTOR_F = (AW + 1)'(SECTOR_WORDS);
  localparam logic [CW-1:0] SECTOR_C = CW'(SECTOR_WORDS);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, XFER, DONE} state_t;

  state_t        state_q, state_d;
  logic          half_q;
  logic [7:0]    hi_q;
  logic          push_q;
  logic [15:0]   push_word_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   rd_data_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          take, pop, push;

  logic [15:0] mem [FIFO_DEPTH];

  always_comb begin
    // wr_en is only meaningful while a sector is open and not yet complete
    take     = wr_en && (state_q == WAIT || state_q == XFER) && (cnt_q != SECTOR_C);
    pop      = take && (fill_q != '0);
    push     = push_q && ((fill_q != DEPTH_V) || pop);
    ovf_d    = ovf_q || (push_q && !push);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (pop && !push) fill_d = fill_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    addr_d  = addr_q;
    cnt_d   = take ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE: if (fill_q >= SECTOR_F && !wr_busy) state_d = REQ;
      REQ: begin
        wr_req  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (wr_busy) state_d = XFER;
      XFER: if (cnt_d == SECTOR_C) state_d = DONE;
      DONE: if (!wr_busy) begin
        addr_d  = addr_q + 32'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q] <= push_word_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      half_q      <= 1'b0;
      hi_q        <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
      cnt_q       <= '0;
      addr_q      <= START_ADDR;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      push_q   <= rx_flag && half_q;
      if (rx_flag) begin
        if (half_q) push_word_q <= {hi_q, rx_data};
        else        hi_q        <= rx_data;
        half_q <= !half_q;
      end
      // Show-ahead head register; forward a word written to the slot being fetched
      rd_data_q <= (push && wr_ptr_q == rd_ptr_d) ? push_word_q : mem[rd_ptr_d];
    end
  end

  assign wr_addr  = addr_q;
  assign wr_data  = rd_data_q;
  assign fill     = fill_q;
  assign overflow = ovf_q;

endmodule
